// File: rtl/mcu_sequencer.sv
// ---------------------------------------------------------------------------
// mcu_sequencer
// Multi-cycle fetch/decode/execute controller for the 8-bit CISC MCU.
// Drives the 32x8 unified program/data memory and holds the accumulator.
//
// Ports
//   clk        in   1  rising-edge clock, shared with memory
//   reset      in   1  asynchronous, active-high
//   READ       out  1  memory read strobe
//   WRITE      out  1  memory write strobe (mutually exclusive with READ)
//   MEM_ADDR   out  5  memory address
//   MEM_DATA1  out  8  write data to memory (the accumulator)
//   MEM_DATA2  in   8  registered read data, valid the cycle after READ
//   acc_out    out  8  accumulator
//   pc_out     out  5  program counter
//   halted     out  1  high while in HALT
// ---------------------------------------------------------------------------
module mcu_sequencer (
    input  logic       clk,
    input  logic       reset,
    output logic       READ,
    output logic       WRITE,
    output logic [4:0] MEM_ADDR,
    output logic [7:0] MEM_DATA1,
    input  logic [7:0] MEM_DATA2,
    output logic [7:0] acc_out,
    output logic [4:0] pc_out,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPRD   = 3'd3,
        S_OPWB   = 3'd4,
        S_STORE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_JNZ   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t     r_state;
    logic [4:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_acc;
    logic       r_read;
    logic       r_write;
    logic [4:0] r_addr;
    logic       r_halted;

    state_t     w_nxt_state;
    logic [4:0] w_nxt_pc;
    logic [7:0] w_nxt_ir;
    logic [7:0] w_nxt_acc;
    logic       w_nxt_read;
    logic       w_nxt_write;
    logic [4:0] w_nxt_addr;
    logic       w_nxt_halted;

    // Accumulator update for the operand-writeback cycle; non-ALU opcodes keep acc.
    function automatic logic [7:0] f_alu(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [7:0] res;
        case (op)
            OP_ADD:  res = a + b;
            OP_AND:  res = a & b;
            OP_SUB:  res = a - b;
            OP_LOAD: res = b;
            default: res = a;
        endcase
        return res;
    endfunction

    // Next-state and datapath update logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_nxt_ir    = r_ir;
        w_nxt_acc   = r_acc;
        case (r_state)
            S_START: begin
                w_nxt_state = S_FETCH;
            end
            S_FETCH: begin
                w_nxt_state = S_DECODE;
            end
            S_DECODE: begin
                // Decode straight from the memory bus; IR is only captured here.
                w_nxt_ir = MEM_DATA2;
                w_nxt_pc = r_pc + 5'd1;
                case (MEM_DATA2[7:5])
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: w_nxt_state = S_OPRD;
                    OP_STORE:                        w_nxt_state = S_STORE;
                    OP_JNZ: begin
                        w_nxt_state = S_FETCH;
                        if (r_acc != 8'd0) begin
                            w_nxt_pc = MEM_DATA2[4:0];
                        end else begin
                            w_nxt_pc = r_pc + 5'd1;
                        end
                    end
                    OP_HALT:                         w_nxt_state = S_HALT;
                    OP_NOP:                          w_nxt_state = S_FETCH;
                    default:                         w_nxt_state = S_FETCH;
                endcase
            end
            S_OPRD: begin
                w_nxt_state = S_OPWB;
            end
            S_OPWB: begin
                w_nxt_acc   = f_alu(r_ir[7:5], r_acc, MEM_DATA2);
                w_nxt_state = S_FETCH;
            end
            S_STORE: begin
                w_nxt_state = S_FETCH;
            end
            S_HALT: begin
                w_nxt_state = S_HALT;
            end
            default: begin
                w_nxt_state = S_START;
            end
        endcase
    end

    // Moore output decode, evaluated on the next state so the outputs can be registered.
    always_comb begin
        w_nxt_read   = (w_nxt_state == S_FETCH) || (w_nxt_state == S_OPRD);
        w_nxt_write  = (w_nxt_state == S_STORE);
        w_nxt_halted = (w_nxt_state == S_HALT);
        if ((w_nxt_state == S_OPRD) || (w_nxt_state == S_OPWB) || (w_nxt_state == S_STORE)) begin
            w_nxt_addr = w_nxt_ir[4:0];
        end else begin
            w_nxt_addr = w_nxt_pc;
        end
    end

    // State, datapath and output registers; reset forces all outputs low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_START;
            r_pc     <= 5'd0;
            r_ir     <= 8'd0;
            r_acc    <= 8'd0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= 5'd0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_pc     <= w_nxt_pc;
            r_ir     <= w_nxt_ir;
            r_acc    <= w_nxt_acc;
            r_read   <= w_nxt_read;
            r_write  <= w_nxt_write;
            r_addr   <= w_nxt_addr;
            r_halted <= w_nxt_halted;
        end
    end

    assign READ      = r_read;
    assign WRITE     = r_write;
    assign MEM_ADDR  = r_addr;
    assign MEM_DATA1 = r_acc;
    assign acc_out   = r_acc;
    assign pc_out    = r_pc;
    assign halted    = r_halted;

endmodule
